// File: rtl/round_pkg.sv
// Shared types, widths and helpers for the round scheduler and its sequence source.
package round_pkg;

    localparam int LVL_W    = 3;
    localparam int PLAYER_W = 4;
    localparam int SEQ_W    = 20;

    localparam logic [PLAYER_W-1:0] NO_WINNER = 4'hF;
    // Feedback taps for x^20 + x^17 + 1 (bits 19 and 16 of a left-shifting register)
    localparam logic [SEQ_W-1:0]    LFSR_TAP  = 20'h90000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SHOW   = 3'd2,
        S_WAIT   = 3'd3,
        S_RESULT = 3'd4,
        S_NEXT   = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    function automatic logic [4:0] count_ones(input logic [15:0] mask);
        logic [4:0] total;
        total = 5'd0;
        for (int i = 0; i < 16; i++) begin
            total = total + {4'd0, mask[i]};
        end
        return total;
    endfunction

    function automatic logic [PLAYER_W-1:0] first_set(input logic [15:0] mask);
        logic [PLAYER_W-1:0] idx;
        logic                hit;
        idx = NO_WINNER;
        hit = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (!hit && mask[i]) begin
                idx = PLAYER_W'(i);
                hit = 1'b1;
            end else begin
                hit = hit;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/round_scheduler_if.sv
// Control/handshake bundle between the game controller, the display and the verifier.
interface round_scheduler_if;
    import round_pkg::*;

    logic                start;
    logic [PLAYER_W-1:0] num_players;
    logic [SEQ_W-1:0]    seed;
    logic                display_done;
    logic                correct;
    logic                incorrect;
    logic                newSequence;
    logic [SEQ_W-1:0]    Sequence;
    logic [LVL_W-1:0]    LVL;
    logic [PLAYER_W-1:0] player_num;
    logic                show_seq;
    logic                busy;
    logic                game_over;
    logic [PLAYER_W-1:0] winner;
    logic                timeout;

    modport master (
        output start, num_players, seed, display_done, correct, incorrect,
        input  newSequence, Sequence, LVL, player_num, show_seq, busy, game_over, winner, timeout
    );

    modport slave (
        input  start, num_players, seed, display_done, correct, incorrect,
        output newSequence, Sequence, LVL, player_num, show_seq, busy, game_over, winner, timeout
    );
endinterface

// File: rtl/round_scheduler_lfsr.sv
// 20-bit Fibonacci LFSR (x^20+x^17+1, shift left); a zero seed is replaced by 1.
module seq_lfsr20
    import round_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [SEQ_W-1:0] seed,
    input  logic             step,
    output logic [SEQ_W-1:0] value
);

    logic [SEQ_W-1:0] value_q;
    logic [SEQ_W-1:0] value_d;

    // Next-state: load has priority over step; the all-zero lock-up state is never loaded
    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = (seed == 20'h00000) ? 20'h00001 : seed;
        end else if (step) begin
            value_d = {value_q[SEQ_W-2:0], ^(value_q & LFSR_TAP)};
        end else begin
            value_d = value_q;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= 20'h00000;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/round_scheduler.sv
// Round-robin turn scheduler sharing the sequence-verify datapath between players.
// Optional verdict timeout is built when ROUND_TIMEOUT_EN is defined.
module round_scheduler
    import round_pkg::*;
#(
    parameter int MAX_PLAYERS = 4,
    parameter int MAX_LVL     = 7
`ifdef ROUND_TIMEOUT_EN
    ,
    parameter int RESP_TIMEOUT = 5000
`endif
) (
    input  logic             clk,
    input  logic             rst,
    round_scheduler_if.slave bus
);

    localparam logic [PLAYER_W-1:0] MAX_P = PLAYER_W'(MAX_PLAYERS);
    localparam logic [LVL_W-1:0]    MAX_L = LVL_W'(MAX_LVL);

    state_t              state_q, state_d;
    logic [PLAYER_W-1:0] player_q, player_d;
    logic [PLAYER_W-1:0] np_q, np_d;
    logic [15:0]         alive_q, alive_d;
    logic [LVL_W-1:0]    level_q [16];
    logic [LVL_W-1:0]    level_d [16];
    logic [PLAYER_W-1:0] winner_q, winner_d;
    logic [SEQ_W-1:0]    seq_q, seq_d;
    logic                pass_q, pass_d;
    logic                lfsr_load_s, lfsr_step_s, start_ok_s, found_s;
    logic [SEQ_W-1:0]    lfsr_value_s;
    logic [PLAYER_W-1:0] cand_s, next_player_s;
    logic [4:0]          remaining_s;
`ifdef ROUND_TIMEOUT_EN
    localparam logic [12:0] TO_LAST = 13'(RESP_TIMEOUT - 1);
    logic [12:0] cnt_q, cnt_d;
    logic        timeout_q, timeout_d;
`endif

    seq_lfsr20 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (lfsr_load_s),
        .seed  (bus.seed),
        .step  (lfsr_step_s),
        .value (lfsr_value_s)
    );

    assign start_ok_s = bus.start && (bus.num_players != 4'd0) && (bus.num_players <= MAX_P);

    // Next alive player after the current one, wrapping at the last active slot
    always_comb begin
        next_player_s = player_q;
        cand_s        = player_q;
        found_s       = 1'b0;
        for (int k = 0; k < MAX_PLAYERS; k++) begin
            cand_s = (cand_s == np_q - 4'd1) ? 4'd0 : cand_s + 4'd1;
            if (!found_s && alive_q[cand_s]) begin
                next_player_s = cand_s;
                found_s       = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state and turn bookkeeping
    always_comb begin
        state_d     = state_q;
        player_d    = player_q;
        np_d        = np_q;
        alive_d     = alive_q;
        level_d     = level_q;
        winner_d    = winner_q;
        seq_d       = seq_q;
        pass_d      = pass_q;
        lfsr_load_s = 1'b0;
        lfsr_step_s = 1'b0;
        remaining_s = 5'd0;
`ifdef ROUND_TIMEOUT_EN
        cnt_d       = cnt_q;
        timeout_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok_s) begin
                    for (int i = 0; i < 16; i++) begin
                        alive_d[i] = (i < int'(bus.num_players));
                        level_d[i] = (i < int'(bus.num_players)) ? 3'd1 : 3'd0;
                    end
                    player_d    = 4'd0;
                    np_d        = bus.num_players;
                    winner_d    = NO_WINNER;
                    lfsr_load_s = 1'b1;
                    state_d     = S_LOAD;
                end else begin
                    state_d = state_q;
                end
            end
            S_LOAD: begin
                lfsr_step_s = 1'b1;
                seq_d       = lfsr_value_s;
                state_d     = S_SHOW;
            end
            S_SHOW: begin
                if (bus.display_done) begin
                    state_d = S_WAIT;
`ifdef ROUND_TIMEOUT_EN
                    cnt_d   = 13'd0;
`endif
                end else begin
                    state_d = S_SHOW;
                end
            end
            S_WAIT: begin
                if (bus.correct || bus.incorrect) begin
                    pass_d  = bus.correct && !bus.incorrect;
                    state_d = S_RESULT;
`ifdef ROUND_TIMEOUT_EN
                end else if (cnt_q == TO_LAST) begin
                    pass_d    = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = S_RESULT;
                end else begin
                    cnt_d = cnt_q + 13'd1;
                end
`else
                end else begin
                    state_d = S_WAIT;
                end
`endif
            end
            S_RESULT: begin
                if (pass_q) begin
                    if (level_q[player_q] == MAX_L) begin
                        winner_d = player_q;
                        state_d  = S_DONE;
                    end else begin
                        level_d[player_q] = level_q[player_q] + 3'd1;
                        state_d           = S_NEXT;
                    end
                end else begin
                    alive_d[player_q] = 1'b0;
                    remaining_s       = count_ones(alive_d);
                    if (remaining_s == 5'd1) begin
                        winner_d = first_set(alive_d);
                        state_d  = S_DONE;
                    end else if (remaining_s == 5'd0) begin
                        winner_d = NO_WINNER;
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                player_d = next_player_s;
                state_d  = S_LOAD;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and per-player registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            player_q <= 4'd0;
            np_q     <= 4'd0;
            alive_q  <= 16'd0;
            winner_q <= NO_WINNER;
            seq_q    <= 20'h00000;
            pass_q   <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                level_q[i] <= 3'd0;
            end
        end else begin
            state_q  <= state_d;
            player_q <= player_d;
            np_q     <= np_d;
            alive_q  <= alive_d;
            winner_q <= winner_d;
            seq_q    <= seq_d;
            pass_q   <= pass_d;
            for (int i = 0; i < 16; i++) begin
                level_q[i] <= level_d[i];
            end
        end
    end

`ifdef ROUND_TIMEOUT_EN
    // Verdict timeout counter and its one-cycle pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= 13'd0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    // Sequence is presented straight from the LFSR during LOAD, then held
    assign bus.Sequence    = (state_q == S_LOAD) ? lfsr_value_s : seq_q;
    assign bus.newSequence = (state_q == S_LOAD);
    assign bus.show_seq    = (state_q == S_SHOW);
    assign bus.busy        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.game_over   = (state_q == S_DONE);
    assign bus.winner      = winner_q;
    assign bus.player_num  = player_q;
    assign bus.LVL         = level_q[player_q];

endmodule

// File: tb/tb_round_scheduler.sv
// Directed bench for round_scheduler: single/multi-player games, restart, verdict corner cases, reset.
module tb_round_scheduler;
    import round_pkg::*;

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    round_scheduler_if bus ();

`ifdef ROUND_TIMEOUT_EN
    round_scheduler #(.MAX_PLAYERS(4), .MAX_LVL(7), .RESP_TIMEOUT(16)) dut (
`else
    round_scheduler #(.MAX_PLAYERS(4), .MAX_LVL(7)) dut (
`endif
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, ".newSequence"}, {31'd0, bus.newSequence}, 32'd0);
        check_eq({tag, ".Sequence"},    {12'd0, bus.Sequence},    32'd0);
        check_eq({tag, ".LVL"},         {29'd0, bus.LVL},         32'd0);
        check_eq({tag, ".player_num"},  {28'd0, bus.player_num},  32'd0);
        check_eq({tag, ".show_seq"},    {31'd0, bus.show_seq},    32'd0);
        check_eq({tag, ".busy"},        {31'd0, bus.busy},        32'd0);
        check_eq({tag, ".game_over"},   {31'd0, bus.game_over},   32'd0);
        check_eq({tag, ".winner"},      {28'd0, bus.winner},      32'hF);
        check_eq({tag, ".timeout"},     {31'd0, bus.timeout},     32'd0);
    endtask

    // Pulse start; returns at the negedge of the cycle after start was sampled
    task automatic do_start(input logic [3:0] np, input logic [19:0] sd);
        @(negedge clk);
        bus.start       = 1'b1;
        bus.num_players = np;
        bus.seed        = sd;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Starts in LOAD, returns in RESULT
    task automatic run_turn(input logic c, input logic ic);
        @(negedge clk);
        check_eq("turn.show_seq", {31'd0, bus.show_seq}, 32'd1);
        bus.display_done = 1'b1;
        @(negedge clk);
        bus.display_done = 1'b0;
        bus.correct      = c;
        bus.incorrect    = ic;
        @(negedge clk);
        bus.correct   = 1'b0;
        bus.incorrect = 1'b0;
    endtask

    task automatic check_load(input string tag, input logic [3:0] p, input logic [2:0] lvl);
        check_eq({tag, ".newSequence"}, {31'd0, bus.newSequence}, 32'd1);
        check_eq({tag, ".player_num"},  {28'd0, bus.player_num},  {28'd0, p});
        check_eq({tag, ".LVL"},         {29'd0, bus.LVL},         {29'd0, lvl});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.num_players  = 4'd0;
        bus.seed         = 20'h0;
        bus.display_done = 1'b0;
        bus.correct      = 1'b0;
        bus.incorrect    = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;

        // 1: single player climbs from level 1 to 7; LFSR seed 1 doubles each step
        do_start(4'd1, 20'h00001);
        for (int k = 0; k < 7; k++) begin
            check_load("t1.load", 4'd0, 3'(k + 1));
            check_eq("t1.seq", {12'd0, bus.Sequence}, 32'd1 << k);
            run_turn(1'b1, 1'b0);
            @(negedge clk);
            if (k < 6) begin
                check_eq("t1.next_busy", {31'd0, bus.busy}, 32'd1);
                @(negedge clk);
            end else begin
                check_eq("t1.game_over", {31'd0, bus.game_over}, 32'd1);
                check_eq("t1.winner",    {28'd0, bus.winner},    32'd0);
                check_eq("t1.busy",      {31'd0, bus.busy},      32'd0);
            end
        end

        // 2: three players, P1 eliminated and skipped thereafter
        do_start(4'd3, 20'h00005);
        check_load("t2.p0a", 4'd0, 3'd1);
        run_turn(1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check_load("t2.p1", 4'd1, 3'd1);
        run_turn(1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check_load("t2.p2a", 4'd2, 3'd1);
        run_turn(1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check_load("t2.p0b", 4'd0, 3'd2);
        run_turn(1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check_load("t2.p2b", 4'd2, 3'd2);
        run_turn(1'b0, 1'b1);
        @(negedge clk);
        check_eq("t2.game_over", {31'd0, bus.game_over}, 32'd1);
        check_eq("t2.winner",    {28'd0, bus.winner},    32'd0);

        // 3: restart from DONE, P0 fails on level 2, P1 wins; restart clears levels
        do_start(4'd2, 20'h00003);
        check_load("t3.p0a", 4'd0, 3'd1);
        check_eq("t3.winner_cleared", {28'd0, bus.winner}, 32'hF);
        run_turn(1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check_load("t3.p1", 4'd1, 3'd1);
        run_turn(1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check_load("t3.p0b", 4'd0, 3'd2);
        run_turn(1'b0, 1'b1);
        @(negedge clk);
        check_eq("t3.game_over", {31'd0, bus.game_over}, 32'd1);
        check_eq("t3.winner",    {28'd0, bus.winner},    32'd1);
        @(negedge clk);
        check_eq("t3.held_winner", {28'd0, bus.winner}, 32'd1);
        do_start(4'd2, 20'h00009);
        check_load("t3.restart", 4'd0, 3'd1);
        check_eq("t3.restart_go", {31'd0, bus.game_over}, 32'd0);

        // 4: verdict during SHOW ignored; correct&incorrect together counts as incorrect
        @(negedge clk);
        bus.correct = 1'b1;
        @(negedge clk);
        bus.correct = 1'b0;
        check_eq("t4.still_show", {31'd0, bus.show_seq}, 32'd1);
        bus.display_done = 1'b1;
        @(negedge clk);
        bus.display_done = 1'b0;
        bus.correct      = 1'b1;
        bus.incorrect    = 1'b1;
        @(negedge clk);
        bus.correct   = 1'b0;
        bus.incorrect = 1'b0;
        @(negedge clk);
        check_eq("t4.both_game_over", {31'd0, bus.game_over}, 32'd1);
        check_eq("t4.both_winner",    {28'd0, bus.winner},    32'd1);

        // 5: out-of-range player counts ignored; zero seed replaced by 1
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        do_start(4'd0, 20'h00007);
        check_eq("t5.np0_busy", {31'd0, bus.busy}, 32'd0);
        do_start(4'd5, 20'h00007);
        check_eq("t5.np5_busy", {31'd0, bus.busy}, 32'd0);
        check_eq("t5.np5_go",   {31'd0, bus.game_over}, 32'd0);
        do_start(4'd1, 20'h00000);
        check_eq("t5.seed0_seq", {12'd0, bus.Sequence}, 32'h00001);
        check_eq("t5.seed0_new", {31'd0, bus.newSequence}, 32'd1);

`ifdef ROUND_TIMEOUT_EN
        // 6a: no verdict -> timeout after 16 WAIT cycles, single player eliminated
        @(negedge clk);
        bus.display_done = 1'b1;
        @(negedge clk);
        bus.display_done = 1'b0;
        repeat (15) @(negedge clk);
        check_eq("t6.no_early_to", {31'd0, bus.timeout}, 32'd0);
        @(negedge clk);
        check_eq("t6.timeout", {31'd0, bus.timeout}, 32'd1);
        @(negedge clk);
        check_eq("t6.to_pulse_end", {31'd0, bus.timeout}, 32'd0);
        check_eq("t6.to_game_over", {31'd0, bus.game_over}, 32'd1);
        check_eq("t6.to_winner",    {28'd0, bus.winner},    32'hF);
        do_start(4'd2, 20'h00011);
`endif

        // 6b: asynchronous reset in SHOW
        @(negedge clk);
        check_eq("t6.in_show", {31'd0, bus.show_seq}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check_reset_vals("t6.rst_show");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("t6.idle_after", {31'd0, bus.busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
